// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcode constants, FSM state type and decode helpers for the
// RV32 pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0]  FUNCT7_MD = 7'b0000001;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } ctrl_state_t;

    // U-type and JAL carry immediate bits where rs1 would sit.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return opcode inside {OP_OP, OP_STORE, OP_BRANCH};
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational decode of the ID and EX instructions: flags a load-use
// dependency and a MUL/DIV instruction sitting in EX.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [31:0] instr_id,
    input  logic [31:0] instr_ex,
    output logic        load_use,
    output logic        ex_md
);

    logic [6:0] w_op_id;
    logic [6:0] w_op_ex;
    logic [4:0] w_rs1_id;
    logic [4:0] w_rs2_id;
    logic [4:0] w_rd_ex;
    logic [6:0] w_funct7_ex;
    logic       w_ex_load;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_unused_bits;

    assign w_op_id     = instr_id[6:0];
    assign w_rs1_id    = instr_id[19:15];
    assign w_rs2_id    = instr_id[24:20];
    assign w_op_ex     = instr_ex[6:0];
    assign w_rd_ex     = instr_ex[11:7];
    assign w_funct7_ex = instr_ex[31:25];

    assign w_ex_load = (w_op_ex == OP_LOAD);
    assign ex_md     = (w_op_ex == OP_OP) && (w_funct7_ex == FUNCT7_MD);

    assign w_rs1_hit = (w_rd_ex == w_rs1_id) && uses_rs1(w_op_id);
    assign w_rs2_hit = (w_rd_ex == w_rs2_id) && uses_rs2(w_op_id);

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign load_use = w_ex_load && (w_rd_ex != 5'd0) && (w_rs1_hit || w_rs2_hit);

    assign w_unused_bits = ^{instr_id[31:25], instr_id[14:7], instr_ex[24:12]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX, EX/WB pipeline registers:
// load-use bubbles, branch squash, fetch wait and multi-cycle MUL/DIV freeze.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_id,
    input  logic [31:0]      instr_ex,
    input  logic             branch_taken_ex,
    input  logic             imem_valid,
    output logic             pc_we,
    output logic             en_pr1,
    output logic             en_pr2,
    output logic             en_pr3,
    output logic             flush_pr1,
    output logic             bubble_pr2,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;
    logic [3:0]       r_md_cnt;
    logic [3:0]       w_md_cnt_nxt;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_load_use;
    logic             w_ex_md;

    hazard_detect u_hazard_detect (
        .instr_id (instr_id),
        .instr_ex (instr_ex),
        .load_use (w_load_use),
        .ex_md    (w_ex_md)
    );

    // NOTE: every output and next-state variable gets a default first, so no
    // path through the priority chain can leave one unassigned and infer a latch.
    always_comb begin
        pc_we        = 1'b0;
        en_pr1       = 1'b0;
        en_pr2       = 1'b0;
        en_pr3       = 1'b0;
        flush_pr1    = 1'b0;
        bubble_pr2   = 1'b0;
        md_busy      = 1'b0;
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;

        if (rst) begin
            unique case (r_state)
                RUN: begin
                    if (w_ex_md) begin
                        w_state_nxt  = MD_BUSY;
                        w_md_cnt_nxt = MD_INIT;
                    end else if (branch_taken_ex) begin
                        {pc_we, en_pr1, en_pr2, en_pr3} = 4'b1111;
                        flush_pr1  = 1'b1;
                        bubble_pr2 = 1'b1;
                    end else if (w_load_use) begin
                        en_pr2     = 1'b1;
                        en_pr3     = 1'b1;
                        bubble_pr2 = 1'b1;
                    end else if (!imem_valid) begin
                        {en_pr1, en_pr2, en_pr3} = 3'b111;
                        flush_pr1 = 1'b1;
                    end else begin
                        {pc_we, en_pr1, en_pr2, en_pr3} = 4'b1111;
                    end
                end
                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (r_md_cnt != 4'd0) begin
                        w_md_cnt_nxt = r_md_cnt - 4'd1;
                    end else begin
                        {pc_we, en_pr1, en_pr2, en_pr3} = 4'b1111;
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_md_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (!pc_we && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a 32-bit and a 4-bit counter
// build share stimulus; expectations are queued per cycle and checked mid-cycle.
module tb_pipeline_hazard_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam logic [31:0] LW_X5        = 32'h0000_A283;
    localparam logic [31:0] LW_X0        = 32'h0000_A003;
    localparam logic [31:0] ADD_X6_X5_X2 = 32'h0022_8333;
    localparam logic [31:0] ADD_X6_X2_X5 = 32'h0051_0333;
    localparam logic [31:0] ADD_X6_X0_X2 = 32'h0020_0333;
    localparam logic [31:0] LUI_X7       = 32'h0002_83B7;
    localparam logic [31:0] MUL_X3       = 32'h0220_81B3;

    // {pc_we, en_pr1, en_pr2, en_pr3, flush_pr1, bubble_pr2, md_busy}
    localparam logic [6:0] E_RST = 7'b000_0000;
    localparam logic [6:0] E_RUN = 7'b111_1000;
    localparam logic [6:0] E_BR  = 7'b111_1110;
    localparam logic [6:0] E_LU  = 7'b001_1010;
    localparam logic [6:0] E_FW  = 7'b011_1100;
    localparam logic [6:0] E_FRZ = 7'b000_0000;
    localparam logic [6:0] E_MDF = 7'b000_0001;
    localparam logic [6:0] E_MDR = 7'b111_1001;

    typedef struct {
        string      tag;
        logic [6:0] outs;
        int         cnt;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_id = NOP_INSTR;
    logic [31:0] instr_ex = NOP_INSTR;
    logic        branch_taken_ex = 1'b0;
    logic        imem_valid = 1'b1;

    logic        pc_we, en_pr1, en_pr2, en_pr3, flush_pr1, bubble_pr2, md_busy;
    logic [31:0] stall_count;
    logic        n_pc_we, n_en_pr1, n_en_pr2, n_en_pr3, n_flush_pr1, n_bubble_pr2, n_md_busy;
    logic [3:0]  n_stall_count;

    sb_item_t sb[$];
    int       exp_cnt  = 0;
    int       n_checks = 0;
    int       n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .instr_ex(instr_ex),
        .branch_taken_ex(branch_taken_ex), .imem_valid(imem_valid),
        .pc_we(pc_we), .en_pr1(en_pr1), .en_pr2(en_pr2), .en_pr3(en_pr3),
        .flush_pr1(flush_pr1), .bubble_pr2(bubble_pr2), .md_busy(md_busy),
        .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .instr_id(instr_id), .instr_ex(instr_ex),
        .branch_taken_ex(branch_taken_ex), .imem_valid(imem_valid),
        .pc_we(n_pc_we), .en_pr1(n_en_pr1), .en_pr2(n_en_pr2), .en_pr3(n_en_pr3),
        .flush_pr1(n_flush_pr1), .bubble_pr2(n_bubble_pr2), .md_busy(n_md_busy),
        .stall_count(n_stall_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Drive one cycle of inputs and queue what the controller must show this cycle.
    task automatic step(input string tag, input logic r, input logic [31:0] iid,
                        input logic [31:0] iex, input logic br, input logic iv,
                        input logic [6:0] exp);
        sb_item_t it;
        @(posedge clk);
        #1;
        rst             = r;
        instr_id        = iid;
        instr_ex        = iex;
        branch_taken_ex = br;
        imem_valid      = iv;
        if (!r) exp_cnt = 0;
        it.tag  = tag;
        it.outs = exp;
        it.cnt  = exp_cnt;
        sb.push_back(it);
        if (r && !exp[6]) exp_cnt++;
    endtask

    // One MUL occupying EX for its full latency, with hazards raised that must be ignored.
    task automatic mul_seq(input string tag);
        step({tag, "_c1"}, 1'b1, NOP_INSTR, MUL_X3, 1'b0, 1'b1, E_FRZ);
        step({tag, "_c2"}, 1'b1, NOP_INSTR, MUL_X3, 1'b1, 1'b0, E_MDF);
        step({tag, "_c3"}, 1'b1, ADD_X6_X5_X2, MUL_X3, 1'b0, 1'b0, E_MDF);
        step({tag, "_c4"}, 1'b1, NOP_INSTR, MUL_X3, 1'b1, 1'b0, E_MDR);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_item_t it;
            it = sb.pop_front();
            check({it.tag, "_outs"},
                  64'({pc_we, en_pr1, en_pr2, en_pr3, flush_pr1, bubble_pr2, md_busy}),
                  64'(it.outs));
            check({it.tag, "_nouts"},
                  64'({n_pc_we, n_en_pr1, n_en_pr2, n_en_pr3, n_flush_pr1, n_bubble_pr2, n_md_busy}),
                  64'(it.outs));
            check({it.tag, "_cnt"}, 64'(stall_count), 64'(it.cnt));
            check({it.tag, "_ncnt"}, 64'(n_stall_count), 64'((it.cnt > 15) ? 15 : it.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        step("rst0", 1'b0, NOP_INSTR, NOP_INSTR, 1'b0, 1'b1, E_RST);
        step("rst1", 1'b0, NOP_INSTR, NOP_INSTR, 1'b0, 1'b1, E_RST);
        step("rel",  1'b1, NOP_INSTR, NOP_INSTR, 1'b0, 1'b1, E_RUN);

        step("lu_rs1",  1'b1, ADD_X6_X5_X2, LW_X5,     1'b0, 1'b1, E_LU);
        step("lu_clr1", 1'b1, ADD_X6_X5_X2, NOP_INSTR, 1'b0, 1'b1, E_RUN);
        step("lu_rs2",  1'b1, ADD_X6_X2_X5, LW_X5,     1'b0, 1'b1, E_LU);
        step("lu_clr2", 1'b1, ADD_X6_X2_X5, NOP_INSTR, 1'b0, 1'b1, E_RUN);
        step("lu_rd0",  1'b1, ADD_X6_X0_X2, LW_X0,     1'b0, 1'b1, E_RUN);
        step("lu_lui",  1'b1, LUI_X7,       LW_X5,     1'b0, 1'b1, E_RUN);

        step("rst_mid", 1'b0, ADD_X6_X5_X2, LW_X5,     1'b0, 1'b1, E_RST);
        step("rst_rel", 1'b1, NOP_INSTR,    NOP_INSTR, 1'b0, 1'b1, E_RUN);

        step("br_lu", 1'b1, ADD_X6_X5_X2, LW_X5,     1'b1, 1'b1, E_BR);
        step("br_fw", 1'b1, NOP_INSTR,    NOP_INSTR, 1'b1, 1'b0, E_BR);

        mul_seq("mul");
        step("mul_done", 1'b1, NOP_INSTR, NOP_INSTR, 1'b0, 1'b1, E_RUN);
        mul_seq("b2b_a");
        mul_seq("b2b_b");
        step("b2b_done", 1'b1, NOP_INSTR, NOP_INSTR, 1'b0, 1'b1, E_RUN);

        step("fw1",     1'b1, NOP_INSTR, NOP_INSTR, 1'b0, 1'b0, E_FW);
        step("fw2",     1'b1, NOP_INSTR, NOP_INSTR, 1'b0, 1'b0, E_FW);
        step("fw_done", 1'b1, NOP_INSTR, NOP_INSTR, 1'b0, 1'b1, E_RUN);

        mul_seq("sat_a");
        mul_seq("sat_b");
        step("sat_done", 1'b1, NOP_INSTR, NOP_INSTR, 1'b0, 1'b1, E_RUN);

        step("mdr_c1",  1'b1, NOP_INSTR, MUL_X3, 1'b0, 1'b1, E_FRZ);
        step("mdr_c2",  1'b1, NOP_INSTR, MUL_X3, 1'b0, 1'b1, E_MDF);
        step("mdr_rst", 1'b0, NOP_INSTR, MUL_X3, 1'b0, 1'b1, E_RST);
        mul_seq("mdr_re");
        step("mdr_done", 1'b1, NOP_INSTR, NOP_INSTR, 1'b0, 1'b1, E_RUN);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
